aes_key_sched_ctrl: RTL and testbench
=====================================

Name: aes_key_sched_ctrl

Overview:
- Iterative AES-128 key-schedule sequencer. Accepts a 128-bit cipher key and produces round keys 0..10, one per output handshake.
- Owns the round counter, the Rcon generator, the current-key register and the word-XOR chain (g-function, then the four cascaded column XORs).
- Shares one external 4-byte combinational S-box with the cipher datapath, so no S-box sits inside this block.
- Sits between key load and the round datapath's AddRoundKey stage.

Parameters:
- NR, 10, number of expansion rounds (last round index).
- RCON_INIT, 8'h01, Rcon value used for round 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  1-cycle request to begin expansion; sampled only in IDLE
- key_in  input  128  cipher key, row-major state layout; sampled on the start cycle
- abort  input  1  synchronous abandon, returns the block to IDLE
- sbox_in  output  32  RotWord of column 3 of the current key, driven to the shared S-box
- sbox_out  input  32  combinational S-box result for sbox_in
- rk_out  output  128  current round key, row-major layout
- rk_round  output  4  index of rk_out, 0..NR
- rk_valid  output  1  rk_out is valid
- rk_ready  input  1  consumer accepts rk_out
- busy  output  1  high whenever the block is not in IDLE
- done  output  1  1-cycle pulse after round NR is accepted

Behaviour:
- Reset (async, rst_n=0): state IDLE; rk_out=0, rk_round=0, rk_valid=0, busy=0, done=0; Rcon register=RCON_INIT.
- Layout:
  - Row r occupies bits [127-32r -: 32].
  - Column c of row r is byte [127-32r-8c -: 8].
  - Word c (column c) = {row0,row1,row2,row3} bytes of column c.
- FSM states: IDLE, EMIT, DONE.
  - IDLE, start=1: load key_in into the key register; rk_round=0; rk_valid=1 from the next cycle; go to EMIT.
  - EMIT, rk_valid & rk_ready, rk_round<NR:
    - key register <= next key.
    - rk_round increments.
    - Rcon <= xtime(Rcon): shift left 1; if the MSB was 1, XOR 8'h1b.
    - rk_valid stays 1, so back-to-back keys stream at 1 per cycle.
  - EMIT, handshake with rk_round==NR: rk_valid<=0; go to DONE.
  - DONE: done=1 for exactly one cycle; return to IDLE; Rcon<=RCON_INIT.
- Backpressure: while rk_valid & !rk_ready, rk_out, rk_round and Rcon hold stable.
- Next-key datapath (combinational from the key register):
  - sbox_in = {row1c3, row2c3, row3c3, row0c3}, i.e. RotWord of w3.
  - temp = sbox_out ^ {Rcon, 24'h0}.
  - n0=temp^w0, n1=n0^w1, n2=n1^w2, n3=n2^w3.
  - Repack n0..n3 into row-major layout.
- sbox_in is driven continuously, including in IDLE; the S-box owner arbitrates externally. sbox_out must be valid in the same cycle.
- start while busy: ignored, no effect on state.
- abort (any non-IDLE state): next cycle goes to IDLE; rk_valid=0, done=0, Rcon=RCON_INIT; rk_out retains its last value.
- abort and start together in IDLE: abort wins, start is ignored.
- Reset mid-expansion: immediate return to reset values; no done pulse.
- Latency:
  - start to round-0 valid: 1 cycle.
  - start to done: NR+2 cycles with rk_ready held at 1.

Test Plan:
- FIPS-197 key, full stream:
  - Stimulus: key_in=128'h2b28ab097eaef7cf15d2154f16a6883c, start=1, rk_ready=1.
  - Round 0 equals key_in.
  - Round 1 = 128'ha088232afa54a36cfe2c397617b13905.
  - Round 10 = 128'hd0c9e1b614ee3f63f9250c0ca889c8a6.
  - done pulses at cycle 12 after start.
- Backpressure: same key, rk_ready low for 3 cycles while rk_round=4. rk_out, rk_round and sbox_in hold stable; the sequence resumes identically with the round-10 value unchanged.
- Rcon wrap: observe Rcon used in rounds 1..10. It must be 01,02,04,08,10,20,40,80,1b,36.
- Abort and restart: abort at rk_round=6. Next cycle busy=0, rk_valid=0, no done pulse. A new start with the same key reproduces round 1 = 128'ha088232afa54a36cfe2c397617b13905.
- start while busy: a start pulse with a different key at rk_round=3 is ignored, and the rounds continue for the original key.
- Async reset mid-run: rst_n low at rk_round=5, asynchronously between clock edges. All outputs are 0 immediately; after release the block is in IDLE and a fresh start works.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 iterative key-schedule sequencer.
// Streams round keys 0..NR through a valid/ready port using an external S-box.
module aes_key_sched_ctrl #(
  parameter int unsigned NR        = 10,
  parameter logic [7:0]  RCON_INIT = 8'h01
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         abort,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] NR_L = 4'(NR);

  state_e         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [3:0]     round_q, round_d;
  logic [7:0]     rcon_q, rcon_d;

  logic [3:0][31:0] w;
  logic [3:0][31:0] n;
  logic [31:0]      temp;
  logic [127:0]     next_key;
  logic [7:0]       rcon_x;

  logic hs;
  logic last;
  logic load;
  logic adv;
  logic clr;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      rcon_q  <= RCON_INIT;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

  // Split the row-major key register into column words
  always_comb begin
    w = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w[c][31-8*r -: 8] = key_q[127-32*r-8*c -: 8];
      end
    end
  end

  assign sbox_in = {w[3][23:0], w[3][31:24]};
  assign temp    = sbox_out ^ {rcon_q, 24'h0};

  // g-function result feeds the cascaded column XOR chain
  always_comb begin
    n[0] = temp ^ w[0];
    n[1] = n[0] ^ w[1];
    n[2] = n[1] ^ w[2];
    n[3] = n[2] ^ w[3];
  end

  // Repack the new columns into row-major layout
  always_comb begin
    next_key = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        next_key[127-32*r-8*c -: 8] = n[c][31-8*r -: 8];
      end
    end
  end

  assign rcon_x = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  assign hs   = (state_q == EMIT) && rk_ready;
  assign last = (round_q == NR_L);
  assign load = (state_q == IDLE) && start && !abort;
  assign adv  = hs && !abort && !last;
  assign clr  = ((state_q != IDLE) && abort) || (state_q == DONE);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (load) state_d = EMIT;
      EMIT: begin
        if (abort)          state_d = IDLE;
        else if (hs && last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Key, round and Rcon updates; abort keeps the last key visible
  always_comb begin
    key_d   = key_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    unique case (1'b1)
      load: begin
        key_d   = key_in;
        round_d = '0;
        rcon_d  = RCON_INIT;
      end
      adv: begin
        key_d   = next_key;
        round_d = round_q + 4'd1;
        rcon_d  = rcon_x;
      end
      clr: begin
        rcon_d = RCON_INIT;
      end
      default: ;
    endcase
  end

  // Moore outputs
  always_comb begin
    rk_out   = key_q;
    rk_round = round_q;
    rk_valid = (state_q == EMIT);
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: FIPS-197 vectors plus random traffic
// against a word-array key-expansion model.
module tb_aes_key_sched_ctrl;

  localparam logic [127:0] K  = 128'h2b28ab097eaef7cf15d2154f16a6883c;
  localparam logic [127:0] R1 = 128'ha088232afa54a36cfe2c397617b13905;
  localparam logic [127:0] RA = 128'hd0c9e1b614ee3f63f9250c0ca889c8a6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         abort = 1'b0;
  logic [31:0]  sbox_in;
  logic [31:0]  sbox_out;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready = 1'b1;
  logic         busy;
  logic         done;

  int tests = 0;
  int fails = 0;

  logic [7:0] sb [256];

  always #5 clk = ~clk;

  aes_key_sched_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .abort    (abort),
    .sbox_in  (sbox_in),
    .sbox_out (sbox_out),
    .rk_out   (rk_out),
    .rk_round (rk_round),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .busy     (busy),
    .done     (done)
  );

  assign sbox_out = {sb[sbox_in[31:24]], sb[sbox_in[23:16]],
                     sb[sbox_in[15:8]], sb[sbox_in[7:0]]};

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] d;
    d = {b, b} << k;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
            ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS-197 word-array expansion, round r repacked row-major
  function automatic logic [127:0] expand_round(input logic [127:0] k, input int r);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] o;
    rc = 8'h01;
    for (int c = 0; c < 4; c++)
      w[c] = {k[127-8*c -: 8], k[95-8*c -: 8], k[63-8*c -: 8], k[31-8*c -: 8]};
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-8*c -: 8] = w[4*r+c][31:24];
      o[95-8*c -: 8]  = w[4*r+c][23:16];
      o[63-8*c -: 8]  = w[4*r+c][15:8];
      o[31-8*c -: 8]  = w[4*r+c][7:0];
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Protocol-level model: which key should be on the port
  logic         m_busy = 1'b0;
  logic         m_valid = 1'b0;
  logic         m_done = 1'b0;
  logic [3:0]   m_idx = '0;
  logic [127:0] m_rk = '0;
  logic [127:0] m_key = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_valid = 0; m_done = 0; m_idx = 0; m_rk = '0;
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (m_busy && abort) begin
      m_busy = 0; m_valid = 0;
    end else if (!m_busy) begin
      if (start && !abort) begin
        m_key = key_in; m_rk = key_in; m_idx = 0;
        m_busy = 1; m_valid = 1;
      end
    end else if (rk_ready) begin
      if (m_idx < 10) begin
        m_idx = m_idx + 1;
        m_rk = expand_round(m_key, int'(m_idx));
      end else begin
        m_valid = 0; m_done = 1;
      end
    end
  end

  // Compare every output against the model each cycle
  always @(negedge clk) begin
    chk("rk_out",   rk_out, m_rk);
    chk("rk_round", 128'(rk_round), 128'(m_idx));
    chk("rk_valid", 128'(rk_valid), 128'(m_valid));
    chk("busy",     128'(busy), 128'(m_busy));
    chk("done",     128'(done), 128'(m_done));
    chk("sbox_in",  128'(sbox_in),
        128'({m_rk[95-24 -: 8], m_rk[63-24 -: 8], m_rk[31-24 -: 8], m_rk[127-24 -: 8]}));
  end

  task automatic do_start(input logic [127:0] k);
    @(negedge clk);
    start = 1'b1;
    key_in = k;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_round(input int r);
    int n;
    n = 0;
    while (!(rk_valid && rk_round == 4'(r)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk($sformatf("timeout_round%0d", r), 128'(rk_round), 128'(r));
  endtask

  task automatic wait_idle();
    int n;
    rk_ready = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("timeout_idle", 128'(busy), 128'(0));
  endtask

  logic [127:0] obs [11];
  logic [7:0]   rcon_exp [10];

  initial begin
    logic [127:0] held;
    logic [31:0]  held_sb;
    logic [7:0]   rc;
    int           n;
    bit           seen;

    rcon_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    build_sbox();
    chk("sbox_00", 128'(sb[8'h00]), 128'(8'h63));
    chk("sbox_53", 128'(sb[8'h53]), 128'(8'hed));
    chk("model_r1", expand_round(K, 1), R1);
    chk("model_r10", expand_round(K, 10), RA);

    #12;
    chk("reset_rk_out", rk_out, 128'h0);
    chk("reset_flags", 128'({rk_valid, busy, done, rk_round}), 128'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Full FIPS-197 stream
    @(negedge clk);
    start = 1'b1;
    key_in = K;
    n = 0;
    seen = 0;
    while (!seen && n < 30) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (rk_valid) obs[rk_round] = rk_out;
      if (done) seen = 1;
    end
    chk("done_latency", 128'(n), 128'(12));
    chk("round0", obs[0], K);
    chk("round1", obs[1], R1);
    chk("round10", obs[10], RA);
    for (int r = 1; r <= 10; r++) begin
      rc = obs[r][127:120] ^ obs[r-1][127:120] ^ sb[obs[r-1][71:64]];
      chk($sformatf("rcon%0d", r), 128'(rc), 128'(rcon_exp[r-1]));
    end
    @(negedge clk);
    chk("done_one_cycle", 128'(done), 128'(0));

    // Backpressure at round 4
    do_start(K);
    wait_round(4);
    rk_ready = 1'b0;
    held = rk_out;
    held_sb = sbox_in;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_rk_out", rk_out, held);
      chk("bp_round", 128'(rk_round), 128'(4));
      chk("bp_sbox_in", 128'(sbox_in), 128'(held_sb));
    end
    rk_ready = 1'b1;
    wait_round(10);
    chk("bp_round10", rk_out, RA);
    wait_idle();

    // Abort at round 6, then restart
    do_start(K);
    wait_round(6);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", 128'({busy, rk_valid, done}), 128'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", 128'(done), 128'(0));
    end
    do_start(K);
    wait_round(1);
    chk("restart_round1", rk_out, R1);
    wait_idle();

    // Start while busy is ignored
    do_start(K);
    wait_round(3);
    start = 1'b1;
    key_in = ~K;
    @(negedge clk);
    start = 1'b0;
    wait_round(10);
    chk("busy_start_round10", rk_out, RA);
    wait_idle();

    // Async reset mid-run
    do_start(K);
    wait_round(5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_rk_out", rk_out, 128'h0);
    chk("areset_flags", 128'({rk_valid, busy, done, rk_round}), 128'h0);
    chk("areset_sbox_in", 128'(sbox_in), 128'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    do_start(K);
    wait_round(1);
    chk("post_reset_round1", rk_out, R1);
    wait_idle();

    // Random keys, ready, abort and stray starts
    for (int it = 0; it < 8; it++) begin
      do_start({$urandom, $urandom, $urandom, $urandom});
      for (int c = 0; c < 40; c++) begin
        rk_ready = ($urandom_range(0, 3) != 0);
        abort = ($urandom_range(0, 39) == 0);
        start = ($urandom_range(0, 9) == 0);
        key_in = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
      end
      abort = 1'b0;
      start = 1'b0;
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
